// File: rtl/rx_frame_decoder.sv
// Receive frame decoder: Modified-Miller bit stream -> bytes (LSb first), odd parity strip, partial last byte.
// Optional CRC_A residue check is built only when the RX_CRC_CHECK_EN macro is defined.
module rx_frame_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_soc,
  input  logic       in_eoc,
  input  logic       in_data,
  input  logic       in_data_valid,
  input  logic       in_error,
  output logic       out_soc,
  output logic       out_eoc,
  output logic [7:0] out_data,
  output logic [2:0] out_data_bits,
  output logic       out_data_valid,
  output logic       out_error,
  output logic       out_crc_ok
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_eoc_pend, w_eoc_pend_nxt;
  logic       w_soc_nxt, w_eoc_nxt, w_dv_nxt, w_err_nxt, w_crc_ok_nxt;
  logic [7:0] w_data_nxt;
  logic [2:0] w_bits_nxt;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

`ifdef RX_CRC_CHECK_EN
  logic [15:0] r_crc, w_crc_nxt;
  logic [1:0]  r_byte_cnt, w_byte_cnt_nxt;  // saturates at 3: only ">= 3 bytes" matters

  // CRC_A (x^16+x^12+x^5+1, reflected) byte update as in ISO/IEC 14443-3 Annex B
  function automatic logic [15:0] crc_a_fold(input logic [15:0] crc, input logic [7:0] byte_in);
    logic [7:0] ch;
    ch = byte_in ^ crc[7:0];
    ch = ch ^ {ch[3:0], 4'h0};
    return {8'h00, crc[15:8]} ^ {ch, 8'h00} ^ {5'b00000, ch, 3'b000} ^ {12'h000, ch[7:4]};
  endfunction
`endif

  // Next-state and next-output decode; in_soc restarts from any state
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_eoc_pend_nxt = 1'b0;
    w_soc_nxt      = 1'b0;
    w_eoc_nxt      = r_eoc_pend;
    w_dv_nxt       = 1'b0;
    w_err_nxt      = 1'b0;
    w_crc_ok_nxt   = 1'b0;
    w_data_nxt     = out_data;
    w_bits_nxt     = out_data_bits;
`ifdef RX_CRC_CHECK_EN
    w_crc_nxt      = r_crc;
    w_byte_cnt_nxt = r_byte_cnt;
`endif
    if (in_soc) begin
      w_soc_nxt     = 1'b1;
      w_state_nxt   = ST_DATA;
      w_bit_cnt_nxt = 3'd0;
      w_shift_nxt   = 8'h00;
`ifdef RX_CRC_CHECK_EN
      w_crc_nxt      = 16'h6363;
      w_byte_cnt_nxt = 2'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_DATA: begin
          if (in_eoc) begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = in_data_valid | in_error;
            if (r_bit_cnt == 3'd0) begin
              w_eoc_nxt = 1'b1;
`ifdef RX_CRC_CHECK_EN
              w_crc_ok_nxt = ~(in_data_valid | in_error) & (r_crc == 16'h0000) & (r_byte_cnt == 2'd3);
`endif
            end else begin
              // partial byte goes out now, its out_eoc one cycle later
              w_dv_nxt       = 1'b1;
              w_data_nxt     = r_shift;
              w_bits_nxt     = r_bit_cnt;
              w_eoc_pend_nxt = 1'b1;
            end
          end else if (in_error) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_ERROR;
          end else if (in_data_valid) begin
            w_shift_nxt[r_bit_cnt] = in_data;
            w_bit_cnt_nxt          = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_state_nxt = ST_PARITY;
            end else begin
              w_state_nxt = ST_DATA;
            end
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_PARITY: begin
          if (in_eoc) begin
            w_err_nxt   = 1'b1;
            w_eoc_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (in_error) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_ERROR;
          end else if (in_data_valid) begin
            w_dv_nxt   = 1'b1;
            w_data_nxt = r_shift;
            w_bits_nxt = 3'd0;
            if (in_data != odd_parity(r_shift)) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_ERROR;
            end else begin
              w_shift_nxt = 8'h00;
              w_state_nxt = ST_DATA;
`ifdef RX_CRC_CHECK_EN
              w_crc_nxt = crc_a_fold(r_crc, r_shift);
              if (r_byte_cnt != 2'd3) begin
                w_byte_cnt_nxt = r_byte_cnt + 2'd1;
              end else begin
                w_byte_cnt_nxt = r_byte_cnt;
              end
`endif
            end
          end else begin
            w_state_nxt = ST_PARITY;
          end
        end
        ST_ERROR: begin
          w_err_nxt = in_error;
          if (in_eoc) begin
            w_eoc_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_ERROR;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt      <= 3'd0;
      r_shift        <= 8'h00;
      r_eoc_pend     <= 1'b0;
      out_soc        <= 1'b0;
      out_eoc        <= 1'b0;
      out_data       <= 8'h00;
      out_data_bits  <= 3'd0;
      out_data_valid <= 1'b0;
      out_error      <= 1'b0;
      out_crc_ok     <= 1'b0;
`ifdef RX_CRC_CHECK_EN
      r_crc          <= 16'h6363;
      r_byte_cnt     <= 2'd0;
`endif
    end else begin
      r_bit_cnt      <= w_bit_cnt_nxt;
      r_shift        <= w_shift_nxt;
      r_eoc_pend     <= w_eoc_pend_nxt;
      out_soc        <= w_soc_nxt;
      out_eoc        <= w_eoc_nxt;
      out_data       <= w_data_nxt;
      out_data_bits  <= w_bits_nxt;
      out_data_valid <= w_dv_nxt;
      out_error      <= w_err_nxt;
      out_crc_ok     <= w_crc_ok_nxt;
`ifdef RX_CRC_CHECK_EN
      r_crc          <= w_crc_nxt;
      r_byte_cnt     <= w_byte_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Randomised frame-level bench for rx_frame_decoder: expected output events come from a frame model.
module tb_rx_frame_decoder;

  logic       clk, rst_n;
  logic       in_soc, in_eoc, in_data, in_data_valid, in_error;
  logic       out_soc, out_eoc, out_data_valid, out_error, out_crc_ok;
  logic [7:0] out_data;
  logic [2:0] out_data_bits;

  rx_frame_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_soc(in_soc), .in_eoc(in_eoc), .in_data(in_data),
    .in_data_valid(in_data_valid), .in_error(in_error),
    .out_soc(out_soc), .out_eoc(out_eoc), .out_data(out_data),
    .out_data_bits(out_data_bits), .out_data_valid(out_data_valid),
    .out_error(out_error), .out_crc_ok(out_crc_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_drv   = 0;
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  last_data = 8'h00;
  logic [2:0]  last_bits = 3'd0;

  // frame description consumed by run_frame
  logic [7:0] fr_b[0:15];
  int         fr_n, fr_kind, fr_fk, fr_fj, fr_pbits;
  logic [7:0] fr_pval;
  bit         fr_noeoc, fr_junk, prev_open;
  logic [15:0] gen_crc;

  localparam int K_OK = 0, K_BADPAR = 1, K_MISSPAR = 2, K_INERR = 3, K_COLL = 4;
  localparam int E_SOC = 0, E_DV = 1, E_ERR = 2, E_EOC = 3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int c, input int k, input logic [7:0] d,
                                     input logic [2:0] b, input logic ok);
    logic [31:0] c32;
    logic [7:0]  k8;
    c32 = 32'(c);
    k8  = 8'(k);
    return {c32, k8, d, 5'b00000, b, 7'b0000000, ok};
  endfunction

  // bitwise reflected CRC-CCITT (0x8408), preset 0x6363, no final inversion
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int k = 0; k < 8; k++) r = (r[0] ^ b[k]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge clk) begin
    if (out_soc)        got_q.push_back(mk(cyc, E_SOC, 8'h00, 3'd0, 1'b0));
    if (out_data_valid) got_q.push_back(mk(cyc, E_DV, out_data, out_data_bits, 1'b0));
    if (out_error)      got_q.push_back(mk(cyc, E_ERR, 8'h00, 3'd0, 1'b0));
    if (out_eoc)        got_q.push_back(mk(cyc, E_EOC, 8'h00, 3'd0, out_crc_ok));
  end

  task automatic drive(input logic soc, input logic eoc, input logic dv, input logic d, input logic err);
    @(negedge clk);
    in_soc = soc; in_eoc = eoc; in_data_valid = dv; in_data = d; in_error = err;
    t_drv = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, rbit(), 1'b0);
  endtask

  task automatic gap();
    if ($urandom_range(0, 3) == 0) idle(1);
  endtask

  task automatic exp_push(input int c, input int k, input logic [7:0] d, input logic [2:0] b, input logic ok);
    exp_q.push_back(mk(c, k, d, b, ok));
    if (k == E_DV) begin
      last_data = d;
      last_bits = b;
    end
  endtask

  task automatic run_frame();
    logic [15:0] crc;
    logic [7:0]  b;
    logic        par, ok;
    int          nfull;
    bit          stop, missing, coll;
    crc = 16'h6363; nfull = 0; stop = 0; missing = 0;
    if (fr_junk) begin
      drive(1'b0, 1'b0, 1'b1, rbit(), 1'b0);
      drive(1'b0, 1'b0, 1'b1, rbit(), 1'b1);
      drive(1'b0, 1'b1, 1'b1, rbit(), 1'b0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_push(t_drv + 1, E_SOC, 8'h00, 3'd0, 1'b0);
    for (int i = 0; i < fr_n && !stop && !missing; i++) begin
      b = fr_b[i];
      for (int j = 0; j < 8; j++) begin
        gap();
        if (fr_kind == K_INERR && i == fr_fk && j == fr_fj) begin
          drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
          exp_push(t_drv + 1, E_ERR, 8'h00, 3'd0, 1'b0);
          stop = 1;
          break;
        end
        drive(1'b0, 1'b0, 1'b1, b[j], 1'b0);
      end
      if (!stop) begin
        if (fr_kind == K_MISSPAR && i == fr_fk) begin
          missing = 1;
        end else begin
          par = ~(^b);
          if (fr_kind == K_BADPAR && i == fr_fk) par = ~par;
          gap();
          drive(1'b0, 1'b0, 1'b1, par, 1'b0);
          exp_push(t_drv + 1, E_DV, b, 3'd0, 1'b0);
          if (fr_kind == K_BADPAR && i == fr_fk) begin
            exp_push(t_drv + 1, E_ERR, 8'h00, 3'd0, 1'b0);
            stop = 1;
          end else begin
            crc = crc_upd(crc, b);
            nfull++;
          end
        end
      end
    end
    if (stop) begin
      for (int q = 0; q < 4; q++) begin
        gap();
        drive(1'b0, 1'b0, 1'b1, rbit(), 1'b0);
      end
      if (!fr_noeoc) begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_push(t_drv + 1, E_EOC, 8'h00, 3'd0, 1'b0);
      end
    end else if (missing) begin
      gap();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_push(t_drv + 1, E_ERR, 8'h00, 3'd0, 1'b0);
      exp_push(t_drv + 1, E_EOC, 8'h00, 3'd0, 1'b0);
    end else begin
      for (int j = 0; j < fr_pbits; j++) begin
        gap();
        drive(1'b0, 1'b0, 1'b1, fr_pval[j], 1'b0);
      end
      coll = (fr_kind == K_COLL);
      gap();
      drive(1'b0, 1'b1, coll, rbit(), 1'b0);
      if (fr_pbits > 0) begin
        exp_push(t_drv + 1, E_DV, fr_pval, 3'(fr_pbits), 1'b0);
        if (coll) exp_push(t_drv + 1, E_ERR, 8'h00, 3'd0, 1'b0);
        exp_push(t_drv + 2, E_EOC, 8'h00, 3'd0, 1'b0);
      end else begin
        if (coll) exp_push(t_drv + 1, E_ERR, 8'h00, 3'd0, 1'b0);
`ifdef RX_CRC_CHECK_EN
        ok = !coll && nfull >= 3 && crc == 16'h0000;
`else
        ok = 1'b0;
`endif
        exp_push(t_drv + 1, E_EOC, 8'h00, 3'd0, ok);
      end
    end
    idle(4);
  endtask

  task automatic compare_frame(input string tag);
    check_val({tag, "_nev"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_val($sformatf("%s_ev%0d", tag, i), got_q[i], exp_q[i]);
    check_val({tag, "_hold"}, 64'({out_data, out_data_bits}), 64'({last_data, last_bits}));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic set_frame(input int kind, input int n, input int pbits, input logic [7:0] pval,
                           input int fk, input int fj, input bit noeoc);
    fr_kind = kind; fr_n = n; fr_pbits = pbits; fr_pval = pval;
    fr_fk = fk; fr_fj = fj; fr_noeoc = noeoc; fr_junk = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_soc = 1'b0; in_eoc = 1'b0; in_data = 1'b0; in_data_valid = 1'b0; in_error = 1'b0;
    prev_open = 0;
    idle(3);
    check_val("reset_outs", 64'({out_soc, out_eoc, out_data, out_data_bits, out_data_valid, out_error, out_crc_ok}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(2);
    got_q.delete();

    set_frame(K_OK, 0, 7, 8'h26, 0, 0, 0);
    run_frame(); compare_frame("reqa");
    fr_b[0] = 8'h50; fr_b[1] = 8'h00; fr_b[2] = 8'h57; fr_b[3] = 8'hCD;
    set_frame(K_OK, 4, 0, 8'h00, 0, 0, 0);
    run_frame(); compare_frame("hlta");
    set_frame(K_BADPAR, 1, 0, 8'h00, 0, 0, 0);
    run_frame(); compare_frame("par_err");
    fr_b[0] = 8'h93;
    set_frame(K_MISSPAR, 1, 0, 8'h00, 0, 0, 0);
    run_frame(); compare_frame("miss_par");
    fr_b[0] = 8'h50; fr_b[1] = 8'h00; fr_b[2] = 8'h57; fr_b[3] = 8'hCC;
    set_frame(K_OK, 4, 0, 8'h00, 0, 0, 0);
    run_frame(); compare_frame("bad_crc");
    fr_b[0] = 8'h93;
    set_frame(K_INERR, 1, 0, 8'h00, 0, 3, 1);
    run_frame(); compare_frame("abort");
    set_frame(K_OK, 0, 7, 8'h26, 0, 0, 0);
    run_frame(); compare_frame("reqa2");

    for (int f = 0; f < 40; f++) begin
      fr_kind = $urandom_range(0, 4);
      fr_n    = $urandom_range(0, 5);
      for (int i = 0; i < 16; i++) fr_b[i] = 8'($urandom);
      if (fr_kind != K_OK && fr_kind != K_COLL && fr_n == 0) fr_n = 1;
      if (fr_kind == K_OK && fr_n > 0 && fr_n <= 4 && $urandom_range(0, 1) == 1) begin
        gen_crc = 16'h6363;
        for (int i = 0; i < fr_n; i++) gen_crc = crc_upd(gen_crc, fr_b[i]);
        fr_b[fr_n] = gen_crc[7:0];
        fr_b[fr_n + 1] = gen_crc[15:8];
        fr_n += 2;
      end
      fr_fk    = $urandom_range(0, (fr_n > 0) ? fr_n - 1 : 0);
      fr_fj    = $urandom_range(0, 7);
      fr_pbits = (fr_kind == K_OK || fr_kind == K_COLL) ? $urandom_range(0, 7) : 0;
      fr_pval  = 8'($urandom) & ((8'd1 << fr_pbits) - 8'd1);
      fr_noeoc = (fr_kind == K_INERR) && ($urandom_range(0, 1) == 1);
      fr_junk  = !prev_open && ($urandom_range(0, 1) == 1);
      run_frame();
      compare_frame($sformatf("rnd%0d_k%0d", f, fr_kind));
      prev_open = fr_noeoc;
    end

    // asynchronous reset in the cycle a byte is being reported
    fr_b[0] = 8'h50;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 8; j++) drive(1'b0, 1'b0, 1'b1, fr_b[0][j], 1'b0);
    drive(1'b0, 1'b0, 1'b1, ~(^fr_b[0]), 1'b0);
    @(posedge clk);
    #1;
    check_val("rst_pre_dv", 64'({out_data_valid, out_data}), 64'({1'b1, 8'h50}));
    rst_n = 1'b0;
    #1;
    check_val("rst_async", 64'({out_soc, out_eoc, out_data, out_data_bits, out_data_valid, out_error, out_crc_ok}), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    @(negedge clk) rst_n = 1'b1;
    in_eoc = 1'b0;
    idle(4);
    check_val("rst_no_eoc", 64'(got_q.size()), 64'd1);
    got_q.delete();
    exp_q.delete();
    last_data = 8'h00;
    last_bits = 3'd0;
    set_frame(K_OK, 0, 7, 8'h26, 0, 0, 0);
    run_frame(); compare_frame("reqa_post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
